// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, control value type and alignment FSM states
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef logic [1:0] ctrl_t;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/tmds_symbol_dec.sv
// rtl/tmds_symbol_dec.sv - combinational 10b TMDS symbol to {is_ctrl, ctrl, byte}
module tmds_symbol_dec
    import tmds_pkg::*;
(
    input  logic [9:0] sym_i,
    output logic       is_ctrl_o,
    output ctrl_t      ctrl_o,
    output logic [7:0] byte_o
);

    logic [7:0] d;

    always_comb begin
        is_ctrl_o = 1'b1;
        ctrl_o    = 2'b00;
        unique case (sym_i)
            TOK_C00: ctrl_o = 2'b00;
            TOK_C01: ctrl_o = 2'b01;
            TOK_C10: ctrl_o = 2'b10;
            TOK_C11: ctrl_o = 2'b11;
            default: is_ctrl_o = 1'b0;
        endcase
    end

    // bit 9 flags an inverted payload, bit 8 selects XOR vs XNOR chaining
    always_comb begin
        d         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
        byte_o    = '0;
        byte_o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            byte_o[i] = sym_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with token-based word alignment
// Optional lock-loss statistics counter: define TMDS_DECODER_STATS_EN.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOCK_TOKENS   = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  data_i,
    output logic        bitslip_o,
    output logic        de_o,
    output logic [1:0]  ctrl_o,
    output logic [7:0]  data_o,
    output logic        aligned_o,
    output logic [15:0] lock_loss_cnt_o
);

    localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
    localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_TOKENS);
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_WINDOW);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES);

    logic       sym_is_ctrl;
    ctrl_t      sym_ctrl;
    logic [7:0] sym_byte;

    tmds_symbol_dec u_sym (
        .sym_i     (data_i),
        .is_ctrl_o (sym_is_ctrl),
        .ctrl_o    (sym_ctrl),
        .byte_o    (sym_byte)
    );

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             bitslip_q, bitslip_d;
    logic             de_q, aligned_q;
    ctrl_t            ctrl_q;
    logic [7:0]       data_q;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        win_d     = win_q;
        settle_d  = settle_q;
        bitslip_d = 1'b0;
        unique case (state_q)
            ST_SEARCH: begin
                if (sym_is_ctrl) begin
                    win_d = '0;
                    if (run_q == RUN_MAX - 1'b1) begin
                        run_d   = RUN_MAX;
                        state_d = ST_LOCKED;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                    if (win_q == WIN_MAX - 1'b1) begin
                        win_d     = '0;
                        settle_d  = '0;
                        bitslip_d = 1'b1;
                        state_d   = ST_SETTLE;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            // The pulse cycle plus SETTLE_CYCLES further cycles are discarded
            ST_SETTLE: begin
                if (settle_q == SET_MAX) begin
                    settle_d = '0;
                    state_d  = ST_SEARCH;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (sym_is_ctrl) begin
                    win_d = '0;
                end else if (win_q == WIN_MAX - 1'b1) begin
                    win_d   = '0;
                    run_d   = '0;
                    state_d = ST_SEARCH;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            win_q     <= '0;
            settle_q  <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            de_q      <= 1'b0;
            ctrl_q    <= 2'b00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            win_q     <= win_d;
            settle_q  <= settle_d;
            bitslip_q <= bitslip_d;
            aligned_q <= (state_d == ST_LOCKED);
            de_q      <= ~sym_is_ctrl;
            ctrl_q    <= sym_is_ctrl ? sym_ctrl : ctrl_q;
            data_q    <= sym_is_ctrl ? 8'h00 : sym_byte;
        end
    end

`ifdef TMDS_DECODER_STATS_EN
    logic        lock_lost;
    logic [15:0] loss_q;

    assign lock_lost = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= 16'h0000;
        end else if (lock_lost && (loss_q != 16'hFFFF)) begin
            loss_q <= loss_q + 16'h0001;
        end
    end

    assign lock_loss_cnt_o = loss_q;
`else
    assign lock_loss_cnt_o = 16'h0000;
`endif

    assign bitslip_o = bitslip_q;
    assign aligned_o = aligned_q;
    assign de_o      = de_q;
    assign ctrl_o    = ctrl_q;
    assign data_o    = data_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - self-checking bench for tmds_decoder with a behavioural model
module tb_tmds_decoder;

    localparam int W = 4096;
    localparam int S = 8;
    localparam int L = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  data_i;
    logic        bitslip_o, de_o, aligned_o;
    logic [1:0]  ctrl_o;
    logic [7:0]  data_o;
    logic [15:0] lock_loss_cnt_o;

    int tests = 0;
    int fails = 0;

    logic [9:0] tok [4];
    initial begin
        tok[0] = 10'b1101010100;
        tok[1] = 10'b0010101011;
        tok[2] = 10'b0101010100;
        tok[3] = 10'b1010101011;
    end

    tmds_decoder #(.SEARCH_WINDOW(W), .LOCK_TOKENS(L), .SETTLE_CYCLES(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_i          (data_i),
        .bitslip_o       (bitslip_o),
        .de_o            (de_o),
        .ctrl_o          (ctrl_o),
        .data_o          (data_o),
        .aligned_o       (aligned_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [9:0] w);
        data_i = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        data_i = 10'h000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] ref_byte(input logic [9:0] w);
        logic [7:0] d, o;
        d    = w[7:0] ^ {8{w[9]}};
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~w[8];
        return o;
    endfunction

    function automatic int tok_index(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == tok[i]) return i;
        return -1;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] t, input int o);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = t[(i + o) % 10];
        return r;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        while (tok_index(w) >= 0) w = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    initial begin
        logic [9:0]  w;
        logic [1:0]  last_c;
        int          ti, slips, pulses, off, cycle, last_pulse;
        logic [15:0] exp_loss;

        rst    = 1'b1;
        data_i = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_de", de_o, 0);
        chk("rst_ctrl", ctrl_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_aligned", aligned_o, 0);
        chk("rst_bitslip", bitslip_o, 0);
        chk("rst_loss", lock_loss_cnt_o, 0);
        rst = 1'b0;

        for (int k = 1; k <= L; k++) begin
            cyc(tok[0]);
            if (k == L - 1) chk("lock_not_yet", aligned_o, 0);
        end
        chk("lock_aligned", aligned_o, 1);
        chk("lock_ctrl", ctrl_o, 0);
        chk("lock_de", de_o, 0);

        cyc(10'b0100000000);
        chk("byte00_de", de_o, 1);
        chk("byte00_data", data_o, 8'h00);
        cyc(10'b0011111111);
        chk("byteFF_data", data_o, 8'hFF);
        cyc(10'b1011111111);
        chk("inv_data", data_o, ref_byte(10'b1011111111));
        chk("hold_ctrl", ctrl_o, 0);
        cyc(tok[3]);
        chk("tok3_ctrl", ctrl_o, 3);
        chk("tok3_data", data_o, 0);
        cyc(rand_data());
        chk("tok3_hold", ctrl_o, 3);
        last_c = 2'd3;

        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 1) == 1) ? tok[$urandom_range(0, 3)] : 10'($urandom_range(0, 1023));
            ti = tok_index(w);
            if (ti >= 0) last_c = 2'(ti);
            cyc(w);
            chk("rnd_de", de_o, (ti < 0) ? 1 : 0);
            chk("rnd_ctrl", ctrl_o, last_c);
            chk("rnd_data", data_o, (ti < 0) ? ref_byte(w) : 8'h00);
            chk("rnd_aligned", aligned_o, 1);
        end

        cyc(tok[0]);
        slips = 0;
        for (int n = 1; n <= W; n++) begin
            w = rand_data();
            cyc(w);
            if (bitslip_o) slips++;
            if (n == W - 1) chk("win_still_locked", aligned_o, 1);
            if (n % 1024 == 0) chk("win_data", data_o, ref_byte(w));
        end
        chk("win_lost", aligned_o, 0);
        chk("win_no_slip", slips, 0);
`ifdef TMDS_DECODER_STATS_EN
        exp_loss = 16'd1;
`else
        exp_loss = 16'd0;
`endif
        chk("win_loss_cnt", lock_loss_cnt_o, exp_loss);

        do_reset();
        for (int k = 0; k < L - 1; k++) cyc(tok[1]);
        cyc(rand_data());
        chk("run_broken", aligned_o, 0);
        for (int k = 1; k <= L; k++) begin
            cyc(tok[1]);
            if (k == L - 1) chk("run2_not_yet", aligned_o, 0);
        end
        chk("run2_aligned", aligned_o, 1);

        do_reset();
        off        = 3;
        pulses     = 0;
        cycle      = 0;
        last_pulse = 0;
        while (!aligned_o && cycle < 12 * (W + S + 1)) begin
            cyc(rot(tok[0], off));
            cycle++;
            if (bitslip_o) begin
                if (pulses > 0) chk("slip_interval", cycle - last_pulse, W + S + 1);
                last_pulse = cycle;
                pulses++;
                off = (off + 1) % 10;
            end
        end
        chk("slip_aligned", aligned_o, 1);
        chk("slip_count", pulses, 7);
        chk("slip_at_most_9", (pulses <= 9) ? 1 : 0, 1);
        chk("slip_offset", off, 0);

        do_reset();
        for (int n = 1; n <= W; n++) cyc(rand_data());
        chk("settle_pulse", bitslip_o, 1);
        cyc(rand_data());
        chk("settle_pulse_width", bitslip_o, 0);
        repeat (2) cyc(tok[3]);
        rst    = 1'b1;
        data_i = tok[3];
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_settle_de", de_o, 0);
        chk("rst_settle_ctrl", ctrl_o, 0);
        chk("rst_settle_data", data_o, 0);
        chk("rst_settle_aligned", aligned_o, 0);
        chk("rst_settle_bitslip", bitslip_o, 0);
        chk("rst_settle_loss", lock_loss_cnt_o, 0);
        for (int k = 1; k <= L; k++) begin
            cyc(tok[2]);
            if (k == L - 1) chk("post_rst_not_yet", aligned_o, 0);
        end
        chk("post_rst_aligned", aligned_o, 1);
        chk("post_rst_ctrl", ctrl_o, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
